// File: rtl/sel_decoder_pkg.sv
// -----------------------------------------------------------------------------
// sel_decoder_pkg
// Shared definitions for the select decoder and its popcount helper:
//   - MODE_* : encodings of the 2-bit output mode input
//   - clog2  : ceiling log2, used to size count buses from a fan-out width
// -----------------------------------------------------------------------------
package sel_decoder_pkg;

    localparam logic [1:0] MODE_LEVEL  = 2'd0;
    localparam logic [1:0] MODE_PULSE  = 2'd1;
    localparam logic [1:0] MODE_STICKY = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    // Ceiling log2 of value (clog2(1) = 0); a count of 0..W needs clog2(W+1) bits.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                res = res + 1;
                rem = rem >>> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sel_decoder_popcount.sv
// -----------------------------------------------------------------------------
// popcount
// Purely combinational population count of a W-bit vector.
// Ports:
//   vec   in  W      vector to count
//   count out CW     number of set bits in vec, CW = clog2(W+1)
// -----------------------------------------------------------------------------
module popcount
    import sel_decoder_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = clog2(W + 1)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] count
);

    // Ripple sum of all bits of vec.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/sel_decoder.sv
// -----------------------------------------------------------------------------
// sel_decoder
// Registered binary-index to one-hot select decoder with LEVEL, PULSE and
// STICKY output modes, out-of-range detection and a popcount of the active
// selects. Every output is registered; latency is exactly one cycle.
// Ports:
//   clk    in  1      clock, rising edge
//   clr    in  1      synchronous active-low reset
//   en     in  1      decode d_in this cycle
//   mode   in  2      0 LEVEL, 1 PULSE, 2 STICKY, 3 reserved (as LEVEL)
//   d_in   in  IN_W   binary select index
//   ack    in  1      clears accumulated bits in STICKY mode
//   d_out  out OUT_W  select bus
//   valid  out 1      d_out non-zero
//   err    out 1      previous cycle had en with d_in >= OUT_W
//   count  out CNT_W  number of set bits in d_out
// -----------------------------------------------------------------------------
module sel_decoder
    import sel_decoder_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16,
    parameter int CNT_W = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  d_in,
    input  logic             ack,
    output logic [OUT_W-1:0] d_out,
    output logic             valid,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam int PC_W = clog2(OUT_W + 1);
    // With full fan-out every index is legal, so range checking folds away.
    localparam bit FULL_FANOUT = (OUT_W == (1 << IN_W));

    logic [OUT_W-1:0] d_out_q, d_out_d;
    logic             valid_q, valid_d;
    logic             err_q,   err_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             prev_en_q;
    logic [IN_W-1:0]  prev_idx_q;
    logic [1:0]       mode_q;

    logic             in_range_s;
    logic [OUT_W-1:0] hot_s;
    logic             mode_chg_s;
    logic             new_req_s;
    logic [PC_W-1:0]  pc_s;

    // Index decode and out-of-range flag.
    always_comb begin
        in_range_s = 1'b1;
        hot_s      = '0;
        if (FULL_FANOUT) begin
            in_range_s = 1'b1;
        end else begin
            in_range_s = (32'(d_in) < 32'(OUT_W));
        end
        if (en && in_range_s) begin
            hot_s = OUT_W'(1'b1) << d_in;
        end else begin
            hot_s = '0;
        end
        err_d = en && !in_range_s;
    end

    // Mode-dependent next select bus; a mode change discards old STICKY bits
    // and counts as a fresh request in PULSE.
    always_comb begin
        mode_chg_s = (mode != mode_q);
        new_req_s  = en && (!prev_en_q || (d_in != prev_idx_q) || mode_chg_s);
        d_out_d    = hot_s;
        case (mode)
            MODE_PULSE: begin
                if (new_req_s) begin
                    d_out_d = hot_s;
                end else begin
                    d_out_d = '0;
                end
            end
            MODE_STICKY: begin
                // ack clears history but a coincident new request survives.
                if (mode_chg_s || ack) begin
                    d_out_d = hot_s;
                end else begin
                    d_out_d = d_out_q | hot_s;
                end
            end
            MODE_LEVEL, MODE_RSVD: begin
                d_out_d = hot_s;
            end
            default: begin
                d_out_d = hot_s;
            end
        endcase
        valid_d = |d_out_d;
        count_d = CNT_W'(pc_s);
    end

    popcount #(
        .W  (OUT_W),
        .CW (PC_W)
    ) u_popcount (
        .vec   (d_out_d),
        .count (pc_s)
    );

    // Output register bank plus request history; clr has priority.
    always_ff @(posedge clk) begin
        if (!clr) begin
            d_out_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            prev_en_q  <= 1'b0;
            prev_idx_q <= '0;
            mode_q     <= MODE_LEVEL;
        end else begin
            d_out_q    <= d_out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            count_q    <= count_d;
            prev_en_q  <= en;
            prev_idx_q <= d_in;
            mode_q     <= mode;
        end
    end

    assign d_out = d_out_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign count = count_q;

endmodule

// File: doc/sel_decoder.md
# sel_decoder

Parametrised, registered index-to-one-hot decoder. It replaces the fixed 4-to-16 select decoder in the datapath: it drives register-file `Rin`/`Rout` strobes and any other one-hot select bus from a binary index. It adds three output modes (level, pulse, sticky), out-of-range detection for non-power-of-two fan-out, and a popcount of active selects. All outputs are registered, with fixed one-cycle latency.

## Interface
- `IN_W`, default 4: index width.
- `OUT_W`, default 16: number of select lines, 1 ≤ OUT_W ≤ 2**IN_W.
- `CNT_W`, default $clog2(OUT_W+1): width of `count`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `clr`  in  1  synchronous, active-low reset.
- `en`  in  1  request: decode `d_in` this cycle.
- `mode`  in  2  0 = LEVEL, 1 = PULSE, 2 = STICKY, 3 = reserved (behaves as LEVEL).
- `d_in`  in  IN_W  binary select index.
- `ack`  in  1  clears accumulated bits in STICKY mode.
- `d_out`  out  OUT_W  one-hot (LEVEL/PULSE) or accumulated (STICKY) select bus.
- `valid`  out  1  `d_out` non-zero.
- `err`  out  1  one-cycle flag: `en` was high with `d_in` ≥ OUT_W.
- `count`  out  CNT_W  number of set bits in `d_out`.

## Operation
- **Reset** (`clr`=0 at an edge): `d_out`=0, `valid`=0, `err`=0, `count`=0. Internal `prev_en`=0 and `prev_idx`=0. Reset takes priority over every other input.
- **Decode:** `hot` = 1<<`d_in` when `en`=1 and `d_in` < OUT_W, otherwise 0. `err` is registered as (`en` && `d_in` ≥ OUT_W). An out-of-range index never sets any `d_out` bit.
- **LEVEL:** next `d_out` = `hot`. The output follows requests one cycle late and drops to 0 the cycle after `en` falls.
- **PULSE:** next `d_out` = `hot` only on a new request, i.e. `en`=1 and (`prev_en`=0 or `d_in`≠`prev_idx`). Otherwise next `d_out` = 0. Holding `en` with a constant index yields exactly one strobe cycle.
- **STICKY:** next `d_out` = (`ack` ? 0 : `d_out`) | `hot`. When `ack` and a valid request coincide, the new bit survives and all older bits clear. Re-requesting an already-set bit is idempotent.
- **Mode change:** if `mode` differs from the previous cycle's registered mode, accumulated state is discarded. Next `d_out` = `hot` filtered by the new mode's rule, with no OR of old bits. PULSE treats a mode switch as a new request.
- `prev_en`/`prev_idx` update every cycle from `en`/`d_in`, regardless of mode.
- `valid` = |next `d_out`. `count` = popcount(next `d_out`). Both are registered alongside `d_out`, so all three are always mutually consistent.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- There is no back-pressure and no combinational input-to-output path.
- `err` is high for exactly one cycle per offending sampled cycle. A held bad index gives continuous `err`.
- Reset mid-STICKY clears all bits at that edge. The first cycle after release behaves as after power-up, so PULSE fires on any `en`=1.
- When OUT_W = 2**IN_W, `err` is constant 0.

## Structure
- A shared package `sel_decoder_pkg` holds the mode constants MODE_LEVEL, MODE_PULSE, MODE_STICKY, MODE_RSVD, and the `clog2` helper if the tool lacks `$clog2`.
- One sub-module, `popcount #(W)`: purely combinational, with a `count` output sized $clog2(W+1). It is reused elsewhere in the datapath.
- The top level contains decode, the mode-select next-state logic, and the output register bank.

## Test plan
- **Reset/LEVEL:** hold `clr`=0 for 2 cycles, then `en`=1, `mode`=0, `d_in`=5 → after 1 edge `d_out`=0x0020, `valid`=1, `count`=1. Drop `en` → `d_out`=0 next cycle.
- **PULSE:** `mode`=1, `en` held for 4 cycles with `d_in`=3, then `d_in`=9 → 0x0008 for exactly one cycle, zeros, then 0x0200 for exactly one cycle.
- **STICKY with ack collision:** `mode`=2, request 1, 4, 4, then `ack`=1 together with `d_in`=7 → `d_out`=0x0002, 0x0012, 0x0012, then 0x0080 with `count`=1.
- **Out-of-range:** OUT_W=10, `d_in`=12, `en`=1, in STICKY with 0x0004 held → `err`=1 for one cycle, `d_out` stays 0x0004.
- **Mode switch and reset mid-operation:** STICKY holding 0x0003, then switch to LEVEL with `d_in`=2 → `d_out`=0x0004. Back in STICKY holding 0x00F0, assert `clr`=0 → `d_out`, `count`, `valid` all 0 after that edge.
- **Reserved mode:** `mode`=3, `d_in`=15 → identical to LEVEL: `d_out`=0x8000, `count`=1.
